// File: rtl/dot_tile_sequencer_if.sv
// Bundles the command, tile-memory, engine and result buses of dot_tile_sequencer.
// The slave modport is the sequencer's view; the master modport is its environment's view.
interface dot_tile_sequencer_if #(
  parameter int N            = 128,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ACT_WIDTH    = 4,
  parameter int PSUM_WIDTH   = 16,
  parameter int ACC_WIDTH    = 24,
  parameter int ADDR_WIDTH   = 6
);
  // Command channel
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [ADDR_WIDTH-1:0]       cmd_base_addr;
  logic [ADDR_WIDTH:0]         cmd_num_tiles;

  // Tile memory read port
  logic                        mem_rd_en;
  logic [ADDR_WIDTH-1:0]       mem_rd_addr;
  logic [N*WEIGHT_WIDTH-1:0]   mem_rd_weights;
  logic [N*ACT_WIDTH-1:0]      mem_rd_acts;

  // Dot-product engine port
  logic                        dot_start;
  logic [N*WEIGHT_WIDTH-1:0]   dot_weights_flat;
  logic [N*ACT_WIDTH-1:0]      dot_acts_flat;
  logic                        dot_done;
  logic [PSUM_WIDTH-1:0]       dot_result;

  // Result channel and status
  logic                        out_valid;
  logic                        out_ready;
  logic [ACC_WIDTH-1:0]        out_result;
  logic                        out_overflow;
  logic                        busy;

  modport slave (
    input  cmd_valid, cmd_base_addr, cmd_num_tiles,
    output cmd_ready,
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_weights, mem_rd_acts,
    output dot_start, dot_weights_flat, dot_acts_flat,
    input  dot_done, dot_result,
    output out_valid, out_result, out_overflow,
    input  out_ready,
    output busy
  );

  modport master (
    output cmd_valid, cmd_base_addr, cmd_num_tiles,
    input  cmd_ready,
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_weights, mem_rd_acts,
    input  dot_start, dot_weights_flat, dot_acts_flat,
    output dot_done, dot_result,
    input  out_valid, out_result, out_overflow,
    output out_ready,
    input  busy
  );
endinterface

// File: rtl/dot_tile_sequencer.sv
// Streams num_tiles consecutive tiles from tile memory through one shared naive_dot engine,
// accumulates the signed partial sums and returns a single wide result over valid/ready.
module dot_tile_sequencer #(
  parameter int N            = 128,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ACT_WIDTH    = 4,
  parameter int PSUM_WIDTH   = 16,
  parameter int ACC_WIDTH    = 24,
  parameter int ADDR_WIDTH   = 6
) (
  input logic                 clk,
  input logic                 rst,
  dot_tile_sequencer_if.slave bus
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]        base_q;
  logic [CNT_W-1:0]             count_q;
  logic [CNT_W-1:0]             issue_cnt;
  logic [CNT_W-1:0]             done_cnt;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic                         ovf_q;
  logic                         dot_start_q;

  logic                         cmd_ready;
  logic                         mem_rd_en;
  logic                         out_valid;
  logic                         accept;
  logic                         acc_en;
  logic                         issue_last;
  logic                         done_last;
  logic signed [ACC_WIDTH-1:0]  psum_ext;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic                         add_ovf;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign accept     = bus.cmd_valid && cmd_ready;
  assign issue_last = (issue_cnt + CNT_ONE) == count_q;

  // Partial sums are only meaningful while a command is in flight.
  assign acc_en     = bus.dot_done && ((state == ISSUE) || (state == DRAIN));
  assign done_last  = acc_en && ((done_cnt + CNT_ONE) == count_q);

  // ---------------------------------------------------------------------------
  // Signed accumulate, wrapping mod 2^ACC_WIDTH
  // ---------------------------------------------------------------------------
  assign psum_ext = ACC_WIDTH'(signed'(bus.dot_result));
  assign acc_sum  = acc_q + psum_ext;
  assign add_ovf  = (acc_q[ACC_WIDTH-1] == psum_ext[ACC_WIDTH-1]) &&
                    (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // forgets to assign one would otherwise infer a latch.
    state_nxt = state;
    cmd_ready = 1'b0;
    mem_rd_en = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          state_nxt = (bus.cmd_num_tiles == '0) ? OUTPUT : ISSUE;
        end
      end
      ISSUE: begin
        mem_rd_en = 1'b1;
        if (issue_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (done_last) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command registers, counters and accumulator
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q      <= '0;
      count_q     <= '0;
      issue_cnt   <= '0;
      done_cnt    <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      dot_start_q <= 1'b0;
    end else begin
      // Read data arrives one cycle after the strobe, so start follows it by one.
      dot_start_q <= mem_rd_en;
      if (accept) begin
        base_q    <= bus.cmd_base_addr;
        count_q   <= bus.cmd_num_tiles;
        issue_cnt <= '0;
        done_cnt  <= '0;
        acc_q     <= '0;
        ovf_q     <= 1'b0;
      end else begin
        if (mem_rd_en) issue_cnt <= issue_cnt + CNT_ONE;
        if (acc_en) begin
          acc_q    <= acc_sum;
          done_cnt <= done_cnt + CNT_ONE;
          if (add_ovf) ovf_q <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.cmd_ready        = cmd_ready;
  assign bus.mem_rd_en        = mem_rd_en;
  // Address arithmetic is ADDR_WIDTH bits wide, so a run past the top wraps to 0.
  assign bus.mem_rd_addr      = base_q + issue_cnt[ADDR_WIDTH-1:0];
  assign bus.dot_start        = dot_start_q;
  assign bus.dot_weights_flat = bus.mem_rd_weights;
  assign bus.dot_acts_flat    = bus.mem_rd_acts;
  assign bus.out_valid        = out_valid;
  assign bus.out_result       = acc_q;
  assign bus.out_overflow     = ovf_q;
  assign bus.busy             = (state != IDLE);

endmodule

// File: tb/tb_dot_tile_sequencer.sv
// Bench for dot_tile_sequencer: two instances (24-bit and 16-bit accumulators) run in lockstep
// against a shared tile memory and a behavioural engine with fixed latency L.
module tb_dot_tile_sequencer;

  localparam int N    = 128;
  localparam int L    = 3;
  localparam int NOUT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus
  logic       cmd_valid;
  logic [5:0] cmd_base;
  logic [6:0] cmd_num;
  logic       out_ready;
  logic       inj;

  logic [N*4-1:0] mem_w [64];
  logic [N*4-1:0] mem_a [64];

  // Per-instance observed outputs
  logic              ov [NOUT];
  logic              cr [NOUT];
  logic              bz [NOUT];
  logic              ds [NOUT];
  logic              re [NOUT];
  logic              of [NOUT];
  logic [5:0]        ad [NOUT];
  logic signed [23:0] res [NOUT];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [15:0] dot_fn(input logic [N*4-1:0] w, input logic [N*4-1:0] a);
    int s = 0;
    for (int i = 0; i < N; i++) begin
      s += int'(signed'(w[i*4 +: 4])) * int'(signed'(a[i*4 +: 4]));
    end
    return s[15:0];
  endfunction

  for (genvar g = 0; g < NOUT; g++) begin : g_inst
    localparam int AW = (g == 0) ? 24 : 16;

    dot_tile_sequencer_if #(.ACC_WIDTH(AW)) bus ();

    dot_tile_sequencer #(.ACC_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    logic [N*4-1:0] rdw, rda;
    logic [L-1:0]   pv;
    logic [15:0]    pd [L];

    always @(posedge clk) begin
      if (bus.mem_rd_en) begin
        rdw <= mem_w[bus.mem_rd_addr];
        rda <= mem_a[bus.mem_rd_addr];
      end
      if (rst) pv <= '0;
      else     pv <= {pv[L-2:0], bus.dot_start};
      if (bus.dot_start) pd[0] <= dot_fn(bus.dot_weights_flat, bus.dot_acts_flat);
      for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
    end

    assign bus.cmd_valid      = cmd_valid;
    assign bus.cmd_base_addr  = cmd_base;
    assign bus.cmd_num_tiles  = cmd_num;
    assign bus.out_ready      = out_ready;
    assign bus.mem_rd_weights = rdw;
    assign bus.mem_rd_acts    = rda;
    assign bus.dot_done       = pv[L-1] | inj;
    assign bus.dot_result     = inj ? 16'd100 : pd[L-1];

    assign ov[g]  = bus.out_valid;
    assign cr[g]  = bus.cmd_ready;
    assign bz[g]  = bus.busy;
    assign ds[g]  = bus.dot_start;
    assign re[g]  = bus.mem_rd_en;
    assign of[g]  = bus.out_overflow;
    assign ad[g]  = bus.mem_rd_addr;
    assign res[g] = 24'(signed'(bus.out_result));
  end

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int base, input int num, input int w, input int a);
    logic [3:0] wn, an;
    wn = 4'(w);
    an = 4'(a);
    for (int i = 0; i < num; i++) begin
      mem_w[(base + i) % 64] = {N{wn}};
      mem_a[(base + i) % 64] = {N{an}};
    end
  endtask

  task automatic check_reset_vals(input string name);
    for (int g = 0; g < NOUT; g++) begin
      check({name, "_cmd_ready"}, 32'(cr[g]), 1);
      check({name, "_rd_en"},     32'(re[g]), 0);
      check({name, "_dot_start"}, 32'(ds[g]), 0);
      check({name, "_out_valid"}, 32'(ov[g]), 0);
      check({name, "_out_result"}, 32'(res[g]), 0);
      check({name, "_overflow"},  32'(of[g]), 0);
      check({name, "_busy"},      32'(bz[g]), 0);
    end
  endtask

  // Issues one command at a negedge in IDLE and follows it through the output handshake.
  task automatic run_cmd(input string name, input int base, input int num, input int hold,
                         input int exp24, input int exp16, input bit ovf24, input bit ovf16);
    int lat, ds_n, ds_first, ds_last, exp_lat;
    logic [5:0] addrs [$];
    check({name, "_cmd_ready_idle"}, 32'(cr[0]), 1);
    cmd_valid = 1'b1;
    cmd_base  = 6'(base);
    cmd_num   = 7'(num);
    lat = -1; ds_n = 0; ds_first = -1; ds_last = -1;
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (re[0]) addrs.push_back(ad[0]);
      if (ds[0]) begin
        ds_n++;
        if (ds_first < 0) ds_first = k;
        ds_last = k;
      end
      if (ov[0]) lat = k;
    end
    exp_lat = (num == 0) ? 1 : num + 2 + L;
    check({name, "_latency"}, lat, exp_lat);
    if (lat < 0) return;

    check({name, "_valid16"},   32'(ov[1]), 1);
    check({name, "_result24"},  32'(res[0]), exp24);
    check({name, "_result16"},  32'(res[1]), exp16);
    check({name, "_ovf24"},     32'(of[0]), 32'(ovf24));
    check({name, "_ovf16"},     32'(of[1]), 32'(ovf16));
    check({name, "_num_starts"}, ds_n, num);
    check({name, "_num_reads"}, addrs.size(), num);
    if (num > 0) begin
      check({name, "_first_start"}, ds_first, 2);
      check({name, "_last_start"},  ds_last, num + 1);
    end
    for (int i = 0; i < addrs.size() && i < num; i++) begin
      check($sformatf("%s_addr%0d", name, i), 32'(addrs[i]), (base + i) % 64);
    end

    // Back-pressure: result held, a pending command is refused, stray done ignored.
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      cmd_num   = 7'd1;
      inj       = (h == 1);
      @(negedge clk);
      inj = 1'b0;
      check({name, "_hold_valid"},     32'(ov[0]), 1);
      check({name, "_hold_result24"},  32'(res[0]), exp24);
      check({name, "_hold_result16"},  32'(res[1]), exp16);
      check({name, "_hold_cmd_ready"}, 32'(cr[0]), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    check({name, "_post_valid"},     32'(ov[0]), 0);
    check({name, "_post_cmd_ready"}, 32'(cr[0]), 1);
    check({name, "_post_busy"},      32'(bz[0]), 0);
  endtask

  typedef struct {
    string name;
    int    base;
    int    num;
    int    w;
    int    a;
    int    hold;
    int    exp24;
    int    exp16;
    bit    ovf24;
    bit    ovf16;
  } vec_t;

  vec_t vecs [8];
  int   seen_valid;

  initial begin
    vecs[0] = '{"single",  0,  1,  1,  1, 0,    128,    128, 1'b0, 1'b0};
    vecs[1] = '{"four",    4,  4,  1,  1, 0,    512,    512, 1'b0, 1'b0};
    vecs[2] = '{"neg3",   10,  3, -1,  1, 5,   -384,   -384, 1'b0, 1'b0};
    vecs[3] = '{"zero",    0,  0,  0,  0, 2,      0,      0, 1'b0, 1'b0};
    vecs[4] = '{"ovf",    20,  4, -8, -8, 0,  32768, -32768, 1'b0, 1'b1};
    vecs[5] = '{"sq7",    30,  2,  7,  7, 0,  12544,  12544, 1'b0, 1'b0};
    vecs[6] = '{"neg5",   40,  5,  7, -8, 1, -35840,  29696, 1'b0, 1'b1};
    vecs[7] = '{"full",   63, 64,  1,  1, 0,   8192,   8192, 1'b0, 1'b0};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_num   = '0;
    out_ready = 1'b0;
    inj       = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem_w[i] = '0;
      mem_a[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Stray done pulses while idle must not leak into the next result.
    inj = 1'b1;
    repeat (2) @(negedge clk);
    inj = 1'b0;

    for (int v = 0; v < 8; v++) begin
      fill(vecs[v].base, vecs[v].num, vecs[v].w, vecs[v].a);
      run_cmd(vecs[v].name, vecs[v].base, vecs[v].num, vecs[v].hold,
              vecs[v].exp24, vecs[v].exp16, vecs[v].ovf24, vecs[v].ovf16);
      @(negedge clk);
    end

    // Address wrap with distinct tiles: 128 + 256 + 384 - 384.
    fill(62, 1, 1, 1);
    fill(63, 1, 2, 1);
    fill(0,  1, 1, 3);
    fill(1,  1, 3, -1);
    run_cmd("wrap", 62, 4, 0, 384, 384, 1'b0, 1'b0);
    @(negedge clk);

    // Reset in the middle of ISSUE aborts with no output.
    fill(50, 4, -8, -8);
    cmd_valid = 1'b1;
    cmd_base  = 6'd50;
    cmd_num   = 7'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort_in_issue_rd_en", 32'(re[0]), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("abort");
    rst = 1'b0;
    seen_valid = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ov[0] || ov[1]) seen_valid++;
    end
    check("abort_no_valid", seen_valid, 0);

    // Recovery after the aborted command.
    fill(0, 1, 1, 1);
    run_cmd("recover", 0, 1, 0, 128, 128, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
